// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder.
//   - padder FSM state encoding
//   - block geometry (word width, words per block, length word positions)
//   - the 0x80 padding marker and the last-word mask/marker helper
package sha256_pkg;

    localparam int BLOCK_WIDTH = 512;
    localparam int LEN_WIDTH   = 64;
    localparam int WORD_WIDTH  = 32;
    localparam int NUM_WORDS   = BLOCK_WIDTH / WORD_WIDTH;

    localparam logic [31:0] MARKER     = 32'h8000_0000;
    localparam logic [3:0]  LEN_HI_IDX = 4'd14;
    localparam logic [3:0]  LEN_LO_IDX = 4'd15;

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_MARK,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO,
        S_EMIT
    } pad_state_t;

    // Keep the first nbytes bytes (MSB first), put 0x80 right after them and
    // zero the rest. A full word (nbytes >= 4) passes through unchanged.
    function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                  input logic [2:0]  nbytes);
        logic [31:0] w;
        case (nbytes)
            3'd0:    w = MARKER;
            3'd1:    w = {data[31:24], 24'h80_0000};
            3'd2:    w = {data[31:16], 16'h8000};
            3'd3:    w = {data[31:8], 8'h80};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha256_last_word_pad.sv
// Combinational last-word padding: masks the unused bytes of the final
// message word and inserts the 0x80 marker after the last valid byte.
// Ports:
//   data    in  32  big-endian message word
//   nbytes  in  3   valid bytes (0..4, values above 4 treated as 4)
//   padded  out 32  masked word with marker inserted
module sha256_last_word_pad
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] padded
);

    assign padded = pad_last_word(data, nbytes);

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a 32-bit word stream into padded 512-bit
// blocks (0x80 marker, zero fill, 64-bit bit length) for the hash core.
// Optional macro SHA256_MSG_PADDER_LE_EN: input words arrive little-endian
// (byte 0 in bits [7:0]) and are byte-swapped on entry.
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   in_data_i/in_nbytes_i/in_last_i        message word, valid bytes, final flag
//   in_valid_i/in_ready_o                  input handshake
//   block_o/block_first_o/block_last_o     padded block and message position
//   block_valid_o/block_ready_i            block handshake
//   busy_o                                 message in progress
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_ACCEPT  | taking message words into the buffer
// S_MARK    | writing the 0x80000000 marker word after a full last word
// S_ZERO    | zero fill up to word 14
// S_LEN_HI  | writing bit_len[63:32] into word 14
// S_LEN_LO  | writing bit_len[31:0] into word 15
// S_EMIT    | block presented to the core, held until accepted
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int BlockWidth = 512,
    parameter int LenWidth   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           in_data_i,
    input  logic [2:0]            in_nbytes_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_first_o,
    output logic                  block_last_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  busy_o
);

    if (BlockWidth != BLOCK_WIDTH) begin : g_bad_block_width
        $error("sha256_msg_padder: BlockWidth must be 512");
    end
    if (LenWidth != LEN_WIDTH) begin : g_bad_len_width
        $error("sha256_msg_padder: LenWidth must be 64");
    end

    pad_state_t            state_q, state_d;
    pad_state_t            resume_q, resume_d;
    pad_state_t            after_accept;
    logic                  last_q, last_d;
    logic [WORD_WIDTH-1:0] buf_q [NUM_WORDS];
    logic [3:0]            word_idx_q;
    logic [LenWidth-1:0]   bit_len_q;
    logic                  first_pending_q;

    logic [31:0] data_eff;
    logic [2:0]  nbytes_eff;
    logic [31:0] pad_word;
    logic        in_fire;

`ifdef SHA256_MSG_PADDER_LE_EN
    assign data_eff = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
    assign data_eff = in_data_i;
`endif

    // Out-of-range byte counts behave as a full word so the FSM never stalls.
    assign nbytes_eff = (in_nbytes_i > 3'd4) ? 3'd4 : in_nbytes_i;
    assign in_fire    = in_valid_i && (state_q == S_ACCEPT);

    sha256_last_word_pad u_last_word_pad (
        .data   (data_eff),
        .nbytes (nbytes_eff),
        .padded (pad_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_ACCEPT;
            resume_q <= S_ACCEPT;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            last_q   <= last_d;
        end
    end

    // Any write into word 15 fills the buffer, so that step detours through
    // S_EMIT and later resumes wherever padding would have continued.
    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        last_d       = last_q;
        after_accept = S_ACCEPT;
        case (state_q)
            S_ACCEPT: begin
                if (in_fire) begin
                    if (!in_last_i)            after_accept = S_ACCEPT;
                    else if (nbytes_eff == 3'd4) after_accept = S_MARK;
                    else                       after_accept = S_ZERO;
                    if (word_idx_q == 4'd15) begin
                        state_d  = S_EMIT;
                        resume_d = after_accept;
                        last_d   = 1'b0;
                    end else begin
                        state_d = after_accept;
                    end
                end
            end
            S_MARK: begin
                if (word_idx_q == 4'd15) begin
                    state_d  = S_EMIT;
                    resume_d = S_ZERO;
                    last_d   = 1'b0;
                end else begin
                    state_d = S_ZERO;
                end
            end
            S_ZERO: begin
                if (word_idx_q == LEN_HI_IDX) begin
                    state_d = S_LEN_HI;
                end else if (word_idx_q == 4'd15) begin
                    state_d  = S_EMIT;
                    resume_d = S_ZERO;
                    last_d   = 1'b0;
                end
            end
            S_LEN_HI: state_d = S_LEN_LO;
            S_LEN_LO: begin
                state_d  = S_EMIT;
                resume_d = S_ACCEPT;
                last_d   = 1'b1;
            end
            S_EMIT: begin
                if (block_ready_i) state_d = last_q ? S_ACCEPT : resume_q;
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_WORDS; i++) buf_q[i] <= '0;
            word_idx_q      <= '0;
            bit_len_q       <= '0;
            first_pending_q <= 1'b1;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (in_fire) begin
                        buf_q[word_idx_q] <= in_last_i ? pad_word : data_eff;
                        bit_len_q         <= bit_len_q + LenWidth'({nbytes_eff, 3'b000});
                        word_idx_q        <= word_idx_q + 4'd1;
                    end
                end
                S_MARK: begin
                    buf_q[word_idx_q] <= MARKER;
                    word_idx_q        <= word_idx_q + 4'd1;
                end
                S_ZERO: begin
                    if (word_idx_q != LEN_HI_IDX) begin
                        buf_q[word_idx_q] <= '0;
                        word_idx_q        <= word_idx_q + 4'd1;
                    end
                end
                S_LEN_HI: begin
                    buf_q[LEN_HI_IDX] <= bit_len_q[LenWidth-1 -: 32];
                    word_idx_q        <= LEN_LO_IDX;
                end
                S_LEN_LO: begin
                    buf_q[LEN_LO_IDX] <= bit_len_q[31:0];
                    word_idx_q        <= 4'd0;
                end
                S_EMIT: begin
                    if (block_ready_i) begin
                        word_idx_q      <= 4'd0;
                        first_pending_q <= 1'b0;
                        if (last_q) begin
                            bit_len_q       <= '0;
                            first_pending_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready_o    = (state_q == S_ACCEPT);
        block_valid_o = (state_q == S_EMIT);
        block_first_o = (state_q == S_EMIT) && first_pending_q;
        block_last_o  = (state_q == S_EMIT) && last_q;
        // Idle only between messages: in ACCEPT, nothing buffered, no message open.
        busy_o        = !((state_q == S_ACCEPT) && (word_idx_q == 4'd0) && first_pending_q);
        block_o       = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            block_o[BlockWidth-1-WORD_WIDTH*i -: WORD_WIDTH] = buf_q[i];
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [31:0]  in_data_i = '0;
    logic [2:0]   in_nbytes_i = '0;
    logic         in_last_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [511:0] block_o;
    logic         block_first_o;
    logic         block_last_o;
    logic         block_valid_o;
    logic         block_ready_i = 1'b0;
    logic         busy_o;

    sha256_msg_padder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_data_i     (in_data_i),
        .in_nbytes_i   (in_nbytes_i),
        .in_last_i     (in_last_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .block_o       (block_o),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] blk_seen[$];
    logic [7:0]   msg_g[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc16_cyc = -1;
    int           valid1_cyc = -2;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        int           nblk;
        exp_t         e;
        p = msg_g;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg_g.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            e.blk   = blk;
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_msg(input bit gaps);
        int          nw;
        int          nb;
        int          budget;
        logic [31:0] word;
        nw = (msg_g.size() + 3) / 4;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
            nb = msg_g.size() - 4 * w;
            if (nb > 4) nb = 4;
            word = $urandom();
            for (int k = 0; k < nb; k++) word[31-8*k -: 8] = msg_g[4*w+k];
`ifdef SHA256_MSG_PADDER_LE_EN
            word = {word[7:0], word[15:8], word[23:16], word[31:24]};
`endif
            in_data_i   = word;
            in_nbytes_i = 3'(nb);
            in_last_i   = (w == nw - 1);
            in_valid_i  = 1'b1;
            budget = 0;
            while (!in_ready_o && budget < 500) begin
                @(negedge clk_i);
                budget++;
            end
            if (budget >= 500) begin
                n_tests++; n_fail++;
                $display("FAIL in_ready_timeout word=%0d actual in_ready=%b required 1", w, in_ready_o);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
            if (w == 15) acc16_cyc = cyc;
            in_valid_i = 1'b0;
            if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk_i);
        end
        in_last_i = 1'b0;
    endtask

    task automatic collect(input int nblk, input int stall);
        int           budget;
        exp_t         e;
        logic [511:0] b0;
        logic         f0, l0, stable;
        for (int k = 0; k < nblk; k++) begin
            budget = 0;
            while (!block_valid_o && budget < 2000) begin
                @(negedge clk_i);
                budget++;
            end
            n_tests++;
            if (budget >= 2000) begin
                n_fail++;
                $display("FAIL block_timeout blk=%0d actual valid=%b required 1", k, block_valid_o);
                return;
            end
            if (k == 0) valid1_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block blk=%0d actual %h required none", k, block_o);
            end else begin
                e = exp_q.pop_front();
                blk_seen.push_back(block_o);
                if (block_o !== e.blk || block_first_o !== e.first || block_last_o !== e.last) begin
                    n_fail++;
                    $display("FAIL block_data blk=%0d actual %h f=%b l=%b required %h f=%b l=%b",
                             k, block_o, block_first_o, block_last_o, e.blk, e.first, e.last);
                end
            end
            if (stall > 0) begin
                b0 = block_o; f0 = block_first_o; l0 = block_last_o; stable = 1'b1;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk_i);
                    if (block_o !== b0 || block_first_o !== f0 || block_last_o !== l0 ||
                        block_valid_o !== 1'b1 || in_ready_o !== 1'b0) stable = 1'b0;
                end
                n_tests++;
                if (stable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL backpressure_stable blk=%0d actual stable=%b required 1", k, stable);
                end
            end
            block_ready_i = 1'b1;
            @(negedge clk_i);
            block_ready_i = 1'b0;
        end
    endtask

    task automatic run_msg(input int stall, input bit gaps);
        int n0;
        n0 = exp_q.size();
        build_expected();
        blk_seen.delete();
        acc16_cyc  = -1;
        valid1_cyc = -2;
        @(negedge clk_i);
        fork
            drive_msg(gaps);
            collect(exp_q.size() - n0, stall);
        join
        n_tests++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL msg_done len=%0d actual left=%0d busy=%b required left=0 busy=0",
                     msg_g.size(), exp_q.size(), busy_o);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (in_ready_o !== 1'b1 || block_valid_o !== 1'b0 || block_first_o !== 1'b0 ||
            block_last_o !== 1'b0 || busy_o !== 1'b0 || block_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs actual rdy=%b v=%b f=%b l=%b busy=%b blk=%h required 1,0,0,0,0,0",
                     in_ready_o, block_valid_o, block_first_o, block_last_o, busy_o, block_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_abc();
        logic [511:0] lit;
        lit = {32'h6162_6380, 448'h0, 32'h0000_0018};
        msg_g = '{8'h61, 8'h62, 8'h63};
        run_msg(0, 1'b0);
        n_tests++;
        if (blk_seen.size() != 1 || blk_seen[0] !== lit) begin
            n_fail++;
            $display("FAIL abc_literal actual n=%0d required n=1 block %h", blk_seen.size(), lit);
        end
    endtask

    task automatic test_empty();
        logic [511:0] lit;
        lit = {32'h8000_0000, 480'h0};
        msg_g.delete();
        run_msg(0, 1'b0);
        n_tests++;
        if (blk_seen.size() != 1 || blk_seen[0] !== lit) begin
            n_fail++;
            $display("FAIL empty_literal actual n=%0d required n=1 block %h", blk_seen.size(), lit);
        end
    endtask

    task automatic test_56_bytes();
        logic [511:0] b0, b1;
        msg_g.delete();
        for (int i = 0; i < 56; i++) msg_g.push_back(8'($urandom()));
        run_msg(0, 1'b1);
        n_tests++;
        if (blk_seen.size() != 2) begin
            n_fail++;
            $display("FAIL len56_blocks actual %0d required 2", blk_seen.size());
        end else begin
            b0 = blk_seen[0];
            b1 = blk_seen[1];
            if (b0[63:32] !== 32'h8000_0000 || b0[31:0] !== 32'h0 ||
                b1 !== {480'h0, 32'h0000_01C0}) begin
                n_fail++;
                $display("FAIL len56_literal actual w14=%h w15=%h b1w15=%h required 80000000 0 000001c0",
                         b0[63:32], b0[31:0], b1[31:0]);
            end
        end
    endtask

    task automatic test_64_bytes();
        logic [511:0] b1;
        msg_g.delete();
        for (int i = 0; i < 64; i++) msg_g.push_back(8'($urandom()));
        run_msg(0, 1'b0);
        n_tests++;
        if (valid1_cyc !== acc16_cyc) begin
            n_fail++;
            $display("FAIL latency16 actual valid cyc=%0d required %0d", valid1_cyc, acc16_cyc);
        end
        n_tests++;
        if (blk_seen.size() == 2) b1 = blk_seen[1];
        else b1 = '0;
        if (b1 !== {32'h8000_0000, 448'h0, 32'h0000_0200}) begin
            n_fail++;
            $display("FAIL len64_block2 actual %h required 80000000..00000200", b1);
        end
    endtask

    task automatic test_lengths();
        int lens[8] = '{1, 2, 55, 57, 63, 65, 119, 120};
        for (int t = 0; t < 8; t++) begin
            msg_g.delete();
            for (int i = 0; i < lens[t]; i++) msg_g.push_back(8'($urandom()));
            run_msg(t % 3, 1'b1);
        end
    endtask

    task automatic test_backpressure();
        msg_g.delete();
        for (int i = 0; i < 64; i++) msg_g.push_back(8'($urandom()));
        run_msg(10, 1'b0);
    endtask

    task automatic test_back_to_back();
        msg_g = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_msg(0, 1'b0);
        msg_g.delete();
        for (int i = 0; i < 70; i++) msg_g.push_back(8'($urandom()));
        run_msg(2, 1'b0);
        test_abc();
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        block_ready_i = 1'b1;
        for (int w = 0; w < 5; w++) begin
            in_data_i   = $urandom();
            in_nbytes_i = 3'd4;
            in_last_i   = 1'b0;
            in_valid_i  = 1'b1;
            @(negedge clk_i);
        end
        in_valid_i    = 1'b0;
        block_ready_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b1 || block_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_msg_busy actual busy=%b v=%b rdy=%b required 1,0,1",
                     busy_o, block_valid_o, in_ready_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if (in_ready_o !== 1'b1 || block_valid_o !== 1'b0 || block_first_o !== 1'b0 ||
            block_last_o !== 1'b0 || busy_o !== 1'b0 || block_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset actual rdy=%b v=%b f=%b l=%b busy=%b blk=%h required 1,0,0,0,0,0",
                     in_ready_o, block_valid_o, block_first_o, block_last_o, busy_o, block_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_56_bytes();
        test_64_bytes();
        test_lengths();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Producer side of the SHA-256 block interface. Takes a 32-bit big-endian message word stream and applies FIPS 180-4 padding: a 0x80 marker byte, zero fill, and the 64-bit bit-length. Emits 512-bit blocks with first/last flags to the hash core over a valid/ready handshake. Sits between the bus/DMA front end and the sha256 core.

Parameters:
BlockWidth, 512, block width in bits; only 512 is legal (elaboration-time assertion).
LenWidth, 64, message bit-length field width; only 64 is legal.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_data_i  in  32  message word, byte 0 in bits [31:24]
in_nbytes_i  in  3  valid bytes in word; must be 4 unless in_last_i; 0..4 on last word
in_last_i  in  1  final word of message
in_valid_i  in  1  word valid
in_ready_o  out  1  padder accepts a word
block_o  out  512  padded block, word 0 in bits [511:480]
block_first_o  out  1  block is the first of a message (core reloads H0..H7)
block_last_o  out  1  block is the final block (digest valid after hashing it)
block_valid_o  out  1  block available
block_ready_i  in  1  core accepts block
busy_o  out  1  message in progress (any state but ACCEPT with word_idx=0 and no pending message)

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous and active-low. Reset clears all state: in_ready_o=1 after reset; block_valid_o, block_first_o, block_last_o, busy_o = 0; block_o = 0.
- Internal state: 16x32 buffer, 4-bit word_idx, 64-bit bit_len, first_pending flag (set at reset and after each last block handshake).
- FSM states are ACCEPT, MARK, ZERO, LEN_HI, LEN_LO, EMIT.
- ACCEPT: in_ready_o=1. On in_valid_i&&in_ready_o:
  - Write in_data_i to buf[word_idx]; add in_nbytes_i*8 to bit_len (mod 2^64).
  - Increment word_idx.
  - Non-last word: if word_idx was 15, go to EMIT with last=0.
  - Last word with nbytes<4: byte nbytes of the written word is forced to 0x80 and the lower bytes to 0; go to ZERO. For nbytes=0 the written word is 0x80000000.
  - Last word with nbytes=4: go to MARK.
  - Last word with nbytes=4 and word_idx=15: go to EMIT (last=0), then MARK.
- MARK: writes 0x80000000 at word_idx, increments, goes to ZERO. One word per cycle, in_ready_o=0.
- ZERO: writes 0 while word_idx≠14.
  - If word_idx reaches 0 (wrapped past 15): go to EMIT with last=0, then resume ZERO in the next block.
  - At word_idx=14: go to LEN_HI.
- LEN_HI writes bit_len[63:32] at word 14; LEN_LO writes bit_len[31:0] at word 15, then goes to EMIT with last=1.
- EMIT:
  - block_valid_o=1; block_o, block_first_o and block_last_o stay stable until block_ready_i.
  - On handshake: word_idx=0; first_pending cleared. If last, bit_len cleared and first_pending set, then return to ACCEPT; otherwise return to the saved resume state (ACCEPT/MARK/ZERO).
  - in_ready_o=0 throughout EMIT.
- Latency: block_valid_o rises the cycle after the 16th data word is accepted. Padding costs one cycle per padded word.
- block_ready_i asserted outside EMIT is ignored. in_nbytes_i outside the legal range gives undefined data but must not hang the FSM (values >4 are treated as 4).
- Reset mid-message discards the partial block and the length; the next accepted word starts a new message with first=1.

Optional Feature:
SHA256_MSG_PADDER_LE_EN
- Defined: each input word is byte-swapped before use, so byte 0 arrives in bits [7:0]. in_nbytes_i counts from the LSB; padding and length placement in the block are unchanged (still big-endian).
- Undefined: no swap; input is big-endian as described above.

Decomposition:
- sha256_pkg: padder state enum, marker constant 32'h8000_0000, LEN_HI_IDX=14, LEN_LO_IDX=15, BlockWidth/word-count constants, and a function for the last-word mask/marker.
- One sub-module, sha256_last_word_pad (combinational): takes data and nbytes, returns the masked word with the 0x80 marker inserted. It keeps the FSM file small.

Test Plan:
- "abc": one word 0x61626300, nbytes=3, last -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018, first=last=1.
- Empty message: nbytes=0, last -> w0=0x80000000, rest 0, first=last=1.
- 56 bytes (14 full words, last on the 14th) -> two blocks:
  - Block 1: w14=0x80000000, w15=0, first=1, last=0.
  - Block 2: w0..w14=0, w15=0x000001C0, first=0, last=1.
- 64 bytes -> two blocks:
  - Block 1: the data, first=1, last=0.
  - Block 2: w0=0x80000000, w15=0x00000200, last=1.
- Backpressure: block_ready_i held low 10 cycles in EMIT -> block_o and flags stable, in_ready_o=0, no word lost. Then two messages back-to-back: the second starts with first=1 and bit_len restarted.
- Assert rst_ni mid-message after 5 words -> all outputs 0, in_ready_o=1. A new "abc" message then produces the first test's block exactly.
